// File: rtl/hnef_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hnef_pkg                                                  |
// | Purpose  : Shared state encodings, player codes and BCD helper.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package hnef_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic PLAYER_ATTACKER = 1'b0;
    localparam logic PLAYER_DEFENDER = 1'b1;

    // Converts 0..99 to two packed BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd2(input int val);
        int tens;
        int ones;
        tens = (val / 10) % 10;
        ones = val % 10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd2_down_counter                                         |
// | Purpose  : Two-digit BCD down counter, load over dec, sticks at 00.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module bcd2_down_counter #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] q,
    output logic       zero
);

    logic [7:0] q_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else if (load) begin
            q_q <= load_val;
        end else if (dec && (q_q != 8'h00)) begin
            if (q_q[3:0] == 4'd0) begin
                q_q <= {q_q[7:4] - 4'd1, 4'd9};
            end else begin
                q_q <= {q_q[7:4], q_q[3:0] - 4'd1};
            end
        end
    end

    assign q    = q_q;
    assign zero = (q_q == 8'h00);

endmodule
`default_nettype wire

// File: rtl/game_turn_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : game_turn_timer                                           |
// | Purpose  : Per-turn BCD countdown driven by game_clk rising edges.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module game_turn_timer
    import hnef_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50,
    parameter int TURN_SECONDS  = 30
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       game_clk,
    input  logic       start,
    input  logic       pause,
    input  logic       move_done,
    output logic       player,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       running,
    output logic       timeout,
    output logic       sec_pulse
);

    localparam int               SUB_W    = $clog2(TICKS_PER_SEC + 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0]       RELOAD   = to_bcd2(TURN_SECONDS);

    state_t           state_q, state_d;
    logic             player_q, player_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             gclk_q;
    logic             running_q, timeout_q, sec_pulse_q;
    logic             w_tick, w_load, w_dec, w_zero;
    logic [7:0]       w_digits;

    assign w_tick = game_clk & ~gclk_q;

    // Zero is acted on one cycle after it appears so 00 is shown while running.
    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        sub_d    = sub_q;
        w_load   = 1'b0;
        w_dec    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (start) begin
                    w_load   = 1'b1;
                    player_d = PLAYER_ATTACKER;
                    sub_d    = '0;
                end else if (move_done) begin
                    w_load   = 1'b1;
                    player_d = ~player_q;
                    sub_d    = '0;
                    if (pause) state_d = ST_PAUSED;
                end else if (w_zero) begin
                    state_d = ST_TIMEOUT;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (w_tick) begin
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        w_dec = 1'b1;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
            end
            ST_PAUSED: begin
                if (start) begin
                    state_d  = ST_RUN;
                    w_load   = 1'b1;
                    player_d = PLAYER_ATTACKER;
                    sub_d    = '0;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (start) begin
                    state_d  = ST_RUN;
                    w_load   = 1'b1;
                    player_d = PLAYER_ATTACKER;
                    sub_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            player_q    <= PLAYER_ATTACKER;
            sub_q       <= '0;
            gclk_q      <= 1'b1;
            running_q   <= 1'b0;
            timeout_q   <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            player_q    <= player_d;
            sub_q       <= sub_d;
            gclk_q      <= game_clk;
            running_q   <= (state_d == ST_RUN);
            timeout_q   <= (state_d == ST_TIMEOUT);
            sec_pulse_q <= w_dec;
        end
    end

    bcd2_down_counter #(
        .RESET_VAL (RELOAD)
    ) u_digits (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (RELOAD),
        .dec      (w_dec),
        .q        (w_digits),
        .zero     (w_zero)
    );

    assign player    = player_q;
    assign secs_tens = w_digits[7:4];
    assign secs_ones = w_digits[3:0];
    assign running   = running_q;
    assign timeout   = timeout_q;
    assign sec_pulse = sec_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_game_turn_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_game_turn_timer                                        |
// | Purpose  : Scoreboard bench: every output change is matched in order.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_game_turn_timer;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_clk = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       move_done = 1'b0;
    logic       player;
    logic [3:0] secs_tens, secs_ones;
    logic       running, timeout, sec_pulse;

    game_turn_timer #(
        .TICKS_PER_SEC (2),
        .TURN_SECONDS  (12)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .game_clk  (game_clk),
        .start     (start),
        .pause     (pause),
        .move_done (move_done),
        .player    (player),
        .secs_tens (secs_tens),
        .secs_ones (secs_ones),
        .running   (running),
        .timeout   (timeout),
        .sec_pulse (sec_pulse)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [11:0] v;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic        mon_en  = 1'b0;
    logic [11:0] last_v  = 12'hfff;

    // Output vector layout: {player, tens, ones, running, timeout, sec_pulse}
    task automatic expect_v(input string n, input logic p, input int secs,
                            input logic r, input logic to, input logic sp);
        exp_t e;
        e.v    = {p, 4'(secs / 10), 4'(secs % 10), r, to, sp};
        e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic expect_sec(input string n, input logic p, input int secs);
        expect_v(n, p, secs, 1'b1, 1'b0, 1'b1);
        expect_v(n, p, secs, 1'b1, 1'b0, 1'b0);
    endtask

    // Every change of the observed outputs must match the next queued entry.
    always @(negedge clk_in) begin
        logic [11:0] cur;
        exp_t        e;
        cur = {player, secs_tens, secs_ones, running, timeout, sec_pulse};
        if (mon_en && (cur !== last_v)) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_change got=%h expected=none t=%0t", cur, $time);
            end else begin
                e = sb_q.pop_front();
                if (cur === e.v) n_pass++;
                else $display("FAIL %s got=%h expected=%h t=%0t", e.name, cur, e.v, $time);
            end
            last_v = cur;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // One game_clk period: 4 cycles high, 4 low; optional move_done on the rising edge.
    task automatic gedge(input logic with_move);
        game_clk  = 1'b1;
        move_done = with_move;
        cyc(1);
        move_done = 1'b0;
        cyc(3);
        game_clk = 1'b0;
        cyc(4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
    endtask

    task automatic pulse_move();
        move_done = 1'b1;
        cyc(1);
        move_done = 1'b0;
        cyc(2);
    endtask

    initial begin
        // Reset with game_clk high; release must not produce a tick.
        cyc(3);
        expect_v("reset", 1'b0, 12, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cyc(3);
        game_clk = 1'b0;
        cyc(3);

        // Countdown with BCD borrow.
        expect_v("start", 1'b0, 12, 1'b1, 1'b0, 1'b0);
        pulse_start();
        expect_sec("cnt_11", 1'b0, 11);
        expect_sec("cnt_10", 1'b0, 10);
        expect_sec("cnt_09", 1'b0, 9);
        repeat (6) gedge(1'b0);

        // Full run to timeout, then inputs ignored until start.
        expect_v("restart", 1'b0, 12, 1'b1, 1'b0, 1'b0);
        pulse_start();
        for (int s = 11; s >= 1; s--) expect_sec("tmo_cnt", 1'b0, s);
        expect_v("zero_shown", 1'b0, 0, 1'b1, 1'b0, 1'b1);
        expect_v("timeout", 1'b0, 0, 1'b0, 1'b1, 1'b0);
        repeat (24) gedge(1'b0);
        repeat (2) gedge(1'b0);
        pulse_move();
        expect_v("tmo_restart", 1'b0, 12, 1'b1, 1'b0, 1'b0);
        pulse_start();

        // Move handover at 07, then sub-count restarts from zero.
        for (int s = 11; s >= 7; s--) expect_sec("to_07", 1'b0, s);
        repeat (10) gedge(1'b0);
        expect_v("move_07", 1'b1, 12, 1'b1, 1'b0, 1'b0);
        pulse_move();
        expect_sec("after_move", 1'b1, 11);
        repeat (2) gedge(1'b0);

        // move_done coincident with the tick that would give 00.
        for (int s = 10; s >= 1; s--) expect_sec("to_01", 1'b1, s);
        repeat (21) gedge(1'b0);
        expect_v("move_beats_zero", 1'b0, 12, 1'b1, 1'b0, 1'b0);
        gedge(1'b1);
        cyc(4);

        // Pause mid-second; ticks and move_done ignored while paused.
        gedge(1'b0);
        expect_v("pause", 1'b0, 12, 1'b0, 1'b0, 1'b0);
        pause = 1'b1;
        cyc(2);
        repeat (5) gedge(1'b0);
        pulse_move();
        expect_v("resume", 1'b0, 12, 1'b1, 1'b0, 1'b0);
        pause = 1'b0;
        cyc(2);
        expect_sec("resume_dec", 1'b0, 11);
        gedge(1'b0);

        // Restart from PAUSED as defender at 05.
        expect_v("move_def", 1'b1, 12, 1'b1, 1'b0, 1'b0);
        pulse_move();
        for (int s = 11; s >= 5; s--) expect_sec("to_05", 1'b1, s);
        repeat (14) gedge(1'b0);
        expect_v("pause_05", 1'b1, 5, 1'b0, 1'b0, 1'b0);
        pause = 1'b1;
        cyc(2);
        expect_v("start_paused", 1'b0, 12, 1'b1, 1'b0, 1'b0);
        pause = 1'b0;
        pulse_start();

        // Reset mid-game at 08.
        for (int s = 11; s >= 8; s--) expect_sec("to_08", 1'b0, s);
        repeat (8) gedge(1'b0);
        expect_v("reset_mid", 1'b0, 12, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(6);

        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain got=%0d pending expected=0 next=%s", sb_q.size(), sb_q[0].name);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
